jtframe_sdram_arb: RTL

- N-slot ROM request arbiter that shares the single SDRAM read port of the board (sdram_req/ack/addr, data_read/data_rdy) among SLOTS game-side requesters.
- Sits between game ROM fetch logic and the board SDRAM controller, in the clk_rom domain.
- Adds round-robin fairness, a one-entry hit cache per slot, abort on loop_rst and invalidation during download.

---
 rtl/jtframe_sdram_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM requesters,
// with a one-word hit cache per slot, loop_rst abort and download invalidation.
module jtframe_sdram_arb #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 22,
  parameter int unsigned DW    = 32
) (
  input  logic                clk_rom,
  input  logic                rst_n,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  input  logic                sdram_ack,
  output logic [AW-1:0]       sdram_addr,
  input  logic [DW-1:0]       data_read,
  input  logic                data_rdy,
  input  logic                loop_rst,
  input  logic                downloading,
  output logic                busy
);

  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, gnt_q, gnt_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                req_q, req_d, busy_q, busy_d;
  logic [SLOTS-1:0]    valid_q, valid_d, ok_q, ok_d;
  logic [SLOTS*AW-1:0] tag_q, tag_d;
  logic [SLOTS*DW-1:0] dout_q, dout_d;
  logic [SLOTS-1:0]    hit, miss;
  logic                gnt_found, fill;
  logic [IW-1:0]       gnt_sel;
  logic [AW-1:0]       gnt_addr;

  // Cache lookup per slot
  always_comb begin
    hit  = '0;
    miss = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      hit[i]  = slot_req[i] & valid_q[i] & (slot_addr[i*AW +: AW] == tag_q[i*AW +: AW]);
      miss[i] = slot_req[i] & ~hit[i];
    end
  end

  // First missing slot after the pointer; later (nearer) candidates overwrite farther ones
  always_comb begin
    gnt_found = 1'b0;
    gnt_sel   = '0;
    gnt_addr  = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (miss[i] && (((32'(ptr_q) + (SLOTS - k)) % SLOTS) == i)) begin
          gnt_found = 1'b1;
          gnt_sel   = IW'(i);
          gnt_addr  = slot_addr[i*AW +: AW];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    req_d   = req_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    dout_d  = dout_q;
    fill    = 1'b0;
    ok_d    = hit & {SLOTS{~downloading}};

    case (state_q)
      IDLE: begin
        if (!downloading && !loop_rst && gnt_found) begin
          gnt_d   = gnt_sel;
          addr_d  = gnt_addr;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (data_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort discards the fetch but keeps cache and pointer
    if (loop_rst) begin
      state_d = IDLE;
      req_d   = 1'b0;
      fill    = 1'b0;
    end

    if (fill) begin
      ptr_d = gnt_q;
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (IW'(i) == gnt_q) begin
          dout_d[i*DW +: DW] = data_read;
          tag_d[i*AW +: AW]  = addr_q;
          valid_d[i]         = 1'b1;
        end
      end
    end

    if (downloading) valid_d = '0;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IW'(SLOTS - 1);
      gnt_q   <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= '0;
      ok_q    <= '0;
      tag_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
      tag_q   <= tag_d;
      dout_q  <= dout_d;
    end
  end

  assign slot_ok    = ok_q;
  assign slot_dout  = dout_q;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign busy       = busy_q;

endmodule
